vga_line_fetch: RTL and testbench
=================================

Name: vga_line_fetch

Overview:
- Sits between the VGA timing generator and the RGB pins; it is the pixel stage downstream of the timing generator and upstream of the colour outputs.
- Prefetches one framebuffer line (FB_W bytes, one byte per pixel, RRGGBB in bits 5:0) from the memory video port into a ping-pong line buffer during horizontal blanking.
- Replays each buffered line SCALE times with SCALE-fold horizontal pixel replication.
- Emits colour bytes aligned with delayed sync and display-area signals.

Parameters:
- FB_BASE, 32'h200, byte address of framebuffer pixel (0,0).
- FB_W, 160, framebuffer width in pixels; must be a multiple of 4.
- FB_H, 120, framebuffer height in lines.
- SCALE, 4, replication factor; FB_W*SCALE = H_ACTIVE and FB_H*SCALE = V_ACTIVE.
- H_ACTIVE, 640, visible pixels per line.
- H_TOTAL, 800, pixel clocks per line.
- V_TOTAL, 525, lines per frame.

Ports:
- clk, in, 1: pixel clock, same as the timing generator.
- reset, in, 1: asynchronous, active-low.
- hcount, in, 10: current pixel column from the timing generator.
- vcount, in, 10: current line from the timing generator.
- da_in, in, 1: display area flag from the timing generator.
- hs_in, in, 1: horizontal sync from the timing generator, active-low.
- vs_in, in, 1: vertical sync from the timing generator, active-low.
- mem_req, out, 1: read request to the video port.
- mem_addr, out, 32: word-aligned byte address of the read.
- mem_gnt, in, 1: request accepted this cycle.
- mem_data, in, 32: read data, valid the cycle after a granted request; byte 0 = lowest address.
- rgb, out, 8: pixel byte; 0 outside the display area.
- da_out, out, 1: da_in delayed 2 cycles.
- hs_out, out, 1: hs_in delayed 2 cycles.
- vs_out, out, 1: vs_in delayed 2 cycles.
- underrun, out, 1: sticky flag; a fetch failed to finish within its line.

Behaviour:
- Reset (async, reset=0): state IDLE, word index 0, mem_req=0, mem_addr=0, rgb=0, da_out=0, hs_out=1, vs_out=1, underrun=0. The line buffer is not cleared. Reset asserted mid-fetch abandons the fetch immediately.
- Line buffer: 2 banks x FB_W/4 words x 32 bits. The display side reads bank fb_y[0], where fb_y = vcount/SCALE. The fetch writes bank (target line)[0].
- Trigger (IDLE only, at hcount==H_ACTIVE), two cases:
  - vcount < FB_H*SCALE-SCALE and vcount%SCALE==SCALE-1: target line = fb_y+1.
  - vcount==V_TOTAL-1: target line = 0.
  - No other line triggers a fetch.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on trigger.
  - FETCH: mem_req=1 and mem_addr = FB_BASE + target*FB_W + 4*k. On mem_gnt, k increments. The grant of k = FB_W/4-1 moves to DRAIN.
  - DRAIN: holds one cycle for the last data word, then returns to IDLE with k=0.
  - Data capture: every cycle after a grant, mem_data is written to bank[target[0]][k_prev].
  - mem_req is held high with a stable address until granted.
- Timeout: if state != IDLE when hcount==H_TOTAL-1, set underrun=1, drop mem_req, and go to IDLE the next cycle. Words already written stay in the buffer; the remainder hold stale data. underrun clears only on reset.
- Display pipeline, latency exactly 2 clocks:
  - Stage 1: registered buffer read of word (hcount/SCALE)/4, with byte select (hcount/SCALE)%4 registered alongside.
  - Stage 2: byte mux registered into rgb, forced to 8'h00 when stage-2 da is 0.
  - hs, vs and da pass through the same 2-stage delay.
- With no mem_gnt stalls, a fetch takes FB_W/4+1 = 41 cycles, well inside the 160-cycle blank.
- Simultaneous events: a trigger during FETCH/DRAIN cannot occur under legal parameters. If one does, it is ignored.

Optional Feature:
- VGA_TESTPAT_EN
  - Defined: adds input port testpat (1 bit). When testpat=1, stage-2 rgb = {2'b00, hcount_d2[9:4]} (vertical colour bars) while da is high. The fetch FSM still runs unchanged.
  - Undefined: the port is absent and rgb always comes from the line buffer.

Decomposition:
- Package vga_pkg holds:
  - Timing constants: H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL.
  - The fetch state enum type: IDLE, FETCH, DRAIN.
  - Function word_count(FB_W) = FB_W/4.
- One sub-module, vga_line_ram: dual-bank simple dual-port RAM with one write port and one registered read port. Address is {bank, word}.

Test Plan:
- mem_gnt tied 1, framebuffer line 1 preset to bytes 0x00..0x9F. At vcount=3, hcount=640: mem_req high 40 consecutive cycles, addresses 0x2A0..0x33C step 4, underrun stays 0.
- On vcount=4..7 with line 1 buffered: rgb at hcount=h+2 equals byte floor(h/4) (e.g. hcount=10 -> rgb=0x02 two cycles later); identical on all four lines.
- hs_in and vs_in pulses: hs_out and vs_out reproduce them exactly 2 cycles later. rgb=0 whenever da_out=0.
- mem_gnt=0 from hcount=640 to the end of the line: mem_req holds address 0x2A0, timeout at hcount=799 sets underrun=1, FSM returns to IDLE, and underrun remains 1 across the following frames.
- At vcount=524, hcount=640: fetch of line 0 starts at address 0x200 into bank 0. The frame's first visible pixel shows the byte at 0x200.
- reset=0 asserted while k=20: mem_req drops immediately, all outputs take their reset values, and no further requests occur until the next trigger.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA line-fetch pixel stage.
//   - Video timing constants for 640x480 @ 800x525 total.
//   - Fetch state machine encoding (IDLE / FETCH / DRAIN).
//   - word_count(): number of 32-bit words holding one framebuffer line.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Four one-byte pixels are packed into each 32-bit memory word.
    function automatic int word_count(input int fb_w);
        return fb_w / 4;
    endfunction

endpackage

// File: rtl/vga_line_ram.sv
// ---------------------------------------------------------------------------
// vga_line_ram
// Ping-pong line buffer: two banks of 2**AW 32-bit words, one write port and
// one registered read port. Both addresses are {bank, word}.
// Ports:
//   clk    - pixel clock
//   we     - write enable
//   waddr  - write address {bank, word}
//   wdata  - write data
//   raddr  - read address {bank, word}
//   rdata  - read data, valid one clock after raddr
// The array has no reset; its contents survive a reset of the fetch logic.
// ---------------------------------------------------------------------------
module vga_line_ram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [31:0]   wdata,
    input  logic [AW:0]   raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_line_fetch.sv
// ---------------------------------------------------------------------------
// vga_line_fetch
// Pixel stage between the VGA timing generator and the RGB pins. During
// horizontal blanking it prefetches the next framebuffer line from the video
// memory port into one bank of a ping-pong line buffer, while the other bank
// is replayed SCALE times with SCALE-fold pixel replication. Colour, sync and
// display-area outputs all lag the timing inputs by exactly two clocks.
//
// Ports:
//   clk, reset          - pixel clock, asynchronous active-low reset
//   hcount, vcount      - current column / line from the timing generator
//   da_in, hs_in, vs_in - display area, hsync (low), vsync (low)
//   mem_req, mem_addr   - read request and word-aligned byte address
//   mem_gnt, mem_data   - grant this cycle; data the cycle after a grant
//   rgb                 - pixel byte (RRGGBB in 5:0), 0 outside display area
//   da_out, hs_out, vs_out - inputs delayed two clocks
//   underrun            - sticky: a fetch did not finish within its line
//
// Optional feature (macro VGA_TESTPAT_EN): adds input testpat; when high the
// visible pixels show vertical colour bars {2'b00, hcount[9:4]} instead of
// buffer contents. The fetch machine is unaffected.
// ---------------------------------------------------------------------------
module vga_line_fetch #(
    parameter logic [31:0] FB_BASE  = 32'h200,
    parameter int          FB_W     = 160,
    parameter int          FB_H     = 120,
    parameter int          SCALE    = 4,
    parameter int          H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int          H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int          V_TOTAL  = vga_pkg::V_TOTAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        da_in,
    input  logic        hs_in,
    input  logic        vs_in,
`ifdef VGA_TESTPAT_EN
    input  logic        testpat,
`endif
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_data,
    output logic [7:0]  rgb,
    output logic        da_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        underrun
);

    import vga_pkg::*;

    localparam int              WC          = word_count(FB_W);
    localparam int              AW          = $clog2(WC);
    localparam logic [9:0]      SCALE_V     = 10'(SCALE);
    localparam logic [9:0]      TRIG_H      = 10'(H_ACTIVE);
    localparam logic [9:0]      LAST_H      = 10'(H_TOTAL - 1);
    localparam logic [9:0]      LAST_V      = 10'(V_TOTAL - 1);
    localparam logic [9:0]      LAST_TRIG_V = 10'(FB_H * SCALE - SCALE);
    localparam logic [AW-1:0]   LAST_K      = AW'(WC - 1);
    localparam logic [31:0]     LINE_BYTES  = 32'(FB_W);

    fetch_state_t  state;
    logic [AW-1:0] k;
    logic          fetch_bank;

    logic [9:0]    fb_y;
    logic          trig_line;
    logic          trig_wrap;
    logic          trigger;
    logic [9:0]    next_target;
    logic [31:0]   next_base;

    logic          cap_valid;
    logic [AW-1:0] cap_word;
    logic          cap_bank;

    logic [9:0]    hpix;
    logic [AW:0]   raddr;
    logic [31:0]   rd_data;
    logic [1:0]    sel_d1;
    logic          da_d1;
    logic          hs_d1;
    logic          vs_d1;
    logic [7:0]    pix_byte;
`ifdef VGA_TESTPAT_EN
    logic          testpat_d1;
    logic [5:0]    bar_d1;
`endif

    // The fetch for framebuffer line n+1 starts at the end of the last
    // replayed copy of line n; the last line of the frame preloads line 0
    // so the next frame's first visible line is already buffered.
    always_comb begin
        fb_y        = vcount / SCALE_V;
        trig_line   = (vcount < LAST_TRIG_V) && ((vcount % SCALE_V) == (SCALE_V - 10'd1));
        trig_wrap   = (vcount == LAST_V);
        trigger     = (hcount == TRIG_H) && (trig_line || trig_wrap);
        next_target = trig_wrap ? 10'd0 : (fb_y + 10'd1);
        next_base   = FB_BASE + (32'(next_target) * LINE_BYTES);
    end

    // Fetch FSM. The address advances only on a grant, so a stalled request
    // keeps a stable address. Running into the last column of the line with
    // a fetch still open abandons it and latches underrun; the bank is then
    // left partly stale, which is preferable to tearing the next line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            k          <= '0;
            fetch_bank <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            underrun   <= 1'b0;
        end else if ((state != IDLE) && (hcount == LAST_H)) begin
            underrun   <= 1'b1;
            mem_req    <= 1'b0;
            state      <= IDLE;
            k          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state      <= FETCH;
                        fetch_bank <= next_target[0];
                        mem_req    <= 1'b1;
                        mem_addr   <= next_base;
                        k          <= '0;
                    end
                end
                FETCH: begin
                    if (mem_gnt) begin
                        if (k == LAST_K) begin
                            state   <= DRAIN;
                            mem_req <= 1'b0;
                        end else begin
                            k        <= k + AW'(1);
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    k     <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory data arrives one cycle after its grant, so the word index and
    // bank are carried forward one cycle to land the write on the right slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_valid <= 1'b0;
            cap_word  <= '0;
            cap_bank  <= 1'b0;
        end else begin
            cap_valid <= mem_req && mem_gnt;
            cap_word  <= k;
            cap_bank  <= fetch_bank;
        end
    end

    // Each buffered pixel covers SCALE columns; four pixels share a word.
    always_comb begin
        hpix  = hcount / SCALE_V;
        raddr = {fb_y[0], AW'(hpix >> 2)};
    end

    vga_line_ram #(
        .AW(AW)
    ) u_line_ram (
        .clk   (clk),
        .we    (cap_valid),
        .waddr ({cap_bank, cap_word}),
        .wdata (mem_data),
        .raddr (raddr),
        .rdata (rd_data)
    );

    // Stage 1: the RAM read is in flight; the byte lane and timing signals
    // are registered alongside so they line up with rd_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_d1     <= 2'd0;
            da_d1      <= 1'b0;
            hs_d1      <= 1'b1;
            vs_d1      <= 1'b1;
`ifdef VGA_TESTPAT_EN
            testpat_d1 <= 1'b0;
            bar_d1     <= 6'd0;
`endif
        end else begin
            sel_d1     <= hpix[1:0];
            da_d1      <= da_in;
            hs_d1      <= hs_in;
            vs_d1      <= vs_in;
`ifdef VGA_TESTPAT_EN
            testpat_d1 <= testpat;
            bar_d1     <= hcount[9:4];
`endif
        end
    end

    // Byte 0 of a word is the lowest framebuffer address, i.e. leftmost pixel.
    always_comb begin
        pix_byte = 8'h00;
        case (sel_d1)
            2'd0: pix_byte = rd_data[7:0];
            2'd1: pix_byte = rd_data[15:8];
            2'd2: pix_byte = rd_data[23:16];
            2'd3: pix_byte = rd_data[31:24];
            default: pix_byte = 8'h00;
        endcase
    end

    // Stage 2: registered outputs; colour is blanked outside the display area.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb    <= 8'h00;
            da_out <= 1'b0;
            hs_out <= 1'b1;
            vs_out <= 1'b1;
        end else begin
            da_out <= da_d1;
            hs_out <= hs_d1;
            vs_out <= vs_d1;
            if (!da_d1) begin
                rgb <= 8'h00;
            end else begin
`ifdef VGA_TESTPAT_EN
                rgb <= testpat_d1 ? {2'b00, bar_d1} : pix_byte;
`else
                rgb <= pix_byte;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_line_fetch
// Scoreboard bench for vga_line_fetch. Stimulus walks selected video lines
// column by column, pushing expected memory addresses and expected pixel
// outputs into queues; two monitor processes pop and compare whenever the
// DUT issues a granted request or presents a pixel. A small framebuffer
// model answers memory reads one cycle after each grant.
// ---------------------------------------------------------------------------
module tb_vga_line_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        da_in;
    logic        hs_in;
    logic        vs_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_data;
    logic [7:0]  rgb;
    logic        da_out;
    logic        hs_out;
    logic        vs_out;
    logic        underrun;
`ifdef VGA_TESTPAT_EN
    logic        testpat = 1'b0;
`endif

    typedef struct {
        logic       da;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
        bit         rgb_known;
    } pix_exp_t;

    pix_exp_t    pix_q[$];
    logic [31:0] addr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          bank_line[2];
    logic        exp_underrun;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic        obs_req;
    logic [31:0] obs_addr;

    always #5 clk = ~clk;

    vga_line_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .hcount   (hcount),
        .vcount   (vcount),
        .da_in    (da_in),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
`ifdef VGA_TESTPAT_EN
        .testpat  (testpat),
`endif
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_gnt  (mem_gnt),
        .mem_data (mem_data),
        .rgb      (rgb),
        .da_out   (da_out),
        .hs_out   (hs_out),
        .vs_out   (vs_out),
        .underrun (underrun)
    );

    // Framebuffer contents: line 1 holds 0x00..0x9F, line 0 holds 0x40+x,
    // other lines a distinct filler pattern.
    function automatic logic [7:0] fb_byte(input logic [31:0] addr);
        int off;
        int line;
        int x;
        off  = int'(addr - 32'h200);
        line = off / 160;
        x    = off % 160;
        if (line == 1) return 8'(x);
        if (line == 0) return 8'(x + 64);
        return 8'(line * 16 + x);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {fb_byte(addr + 32'd3), fb_byte(addr + 32'd2),
                fb_byte(addr + 32'd1), fb_byte(addr)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one pixel clock of timing inputs just after the active edge,
    // answer the memory port, and record the expected output two clocks on.
    task automatic apply_stimulus(input int h, input int v, input logic gnt,
                                  input logic rst);
        pix_exp_t e;
        int line;
        @(posedge clk);
        #1;
        obs_req  = mem_req;
        obs_addr = mem_addr;
        mem_data = pend_valid ? mem_word(pend_addr) : 32'h0;
        hcount   = 10'(h);
        vcount   = 10'(v);
        da_in    = (h < 640) && (v < 480);
        hs_in    = !((h >= 656) && (h < 752));
        vs_in    = !((v == 490) || (v == 491));
        mem_gnt  = gnt;
        reset    = rst;
        pend_valid = obs_req && gnt && rst;
        pend_addr  = obs_addr;
        if (rst) begin
            e.da = da_in;
            e.hs = hs_in;
            e.vs = vs_in;
            if (!da_in) begin
                e.rgb       = 8'h00;
                e.rgb_known = 1'b1;
            end else begin
                line        = v / 4;
                e.rgb_known = (bank_line[line % 2] == line);
                e.rgb       = fb_byte(32'h200 + 32'(line * 160 + h / 4));
            end
            pix_q.push_back(e);
        end
    endtask

    // One full 800-column line. exp_reqs is the hand-counted number of
    // cycles mem_req should be seen high; reset_h >= 0 pulses reset there.
    task automatic run_line(input int v, input bit gnt_mode, input int reset_h,
                            input int exp_reqs);
        int req_cnt;
        int first_h;
        bit trig;
        int target;
        req_cnt = 0;
        first_h = -1;
        trig    = ((v < 476) && (v % 4 == 3)) || (v == 524);
        target  = (v == 524) ? 0 : v / 4 + 1;
        for (int h = 0; h < 800; h++) begin
            logic rst_now;
            logic gnt_now;
            rst_now = !((reset_h >= 0) && (h >= reset_h) && (h < reset_h + 4));
            gnt_now = gnt_mode || (h < 640);
            apply_stimulus(h, v, gnt_now, rst_now);
            if (obs_req) begin
                req_cnt++;
                if (first_h < 0) first_h = h;
            end
            if (trig && gnt_mode && (h == 640)) begin
                for (int k = 0; k < 40; k++) begin
                    addr_q.push_back(32'h200 + 32'(target * 160 + 4 * k));
                end
            end
            if ((reset_h >= 0) && (h == reset_h)) begin
                check_output("words_granted_before_reset", 32'(addr_q.size()), 32'd20);
                addr_q.delete();
                pix_q.delete();
                exp_underrun = 1'b0;
                #1;
                check_output("rst_mem_req", mem_req, 1'b0);
                check_output("rst_mem_addr", mem_addr, 32'h0);
                check_output("rst_rgb", rgb, 8'h00);
                check_output("rst_da_out", da_out, 1'b0);
                check_output("rst_hs_out", hs_out, 1'b1);
                check_output("rst_vs_out", vs_out, 1'b1);
                check_output("rst_underrun", underrun, 1'b0);
            end
            if (trig && !gnt_mode && ((h == 700) || (h == 799))) begin
                check_output("stalled_req", obs_req, 1'b1);
                check_output("stalled_addr", obs_addr, 32'h200 + 32'(target * 160));
            end
            if (h == 799) begin
                check_output("underrun", underrun, exp_underrun);
            end
        end
        check_output("req_cycles", 32'(req_cnt), 32'(exp_reqs));
        if (exp_reqs > 0) begin
            check_output("req_first_col", 32'(first_h), 32'd641);
        end
        if (reset_h < 0) begin
            check_output("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        end
        if (trig && gnt_mode && (reset_h < 0)) begin
            bank_line[target % 2] = target;
        end
        if (trig && !gnt_mode) begin
            exp_underrun = 1'b1;
        end
    endtask

    // Pixel monitor: the third queued entry onward is due once the 2-stage
    // pipeline has filled.
    always @(negedge clk) begin
        pix_exp_t e;
        if ((reset === 1'b1) && (pix_q.size() >= 3)) begin
            e = pix_q.pop_front();
            check_output("da_out", da_out, e.da);
            check_output("hs_out", hs_out, e.hs);
            check_output("vs_out", vs_out, e.vs);
            if (e.rgb_known) begin
                check_output("rgb", rgb, e.rgb);
            end
        end
    end

    // Request monitor: every granted request must match the next expected
    // address in order.
    always @(negedge clk) begin
        if ((reset === 1'b1) && (mem_req === 1'b1) && (mem_gnt === 1'b1)) begin
            if (addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_req: got addr 0x%0h, expected no request at t=%0t",
                         mem_addr, $time);
            end else begin
                check_output("mem_addr", mem_addr, addr_q.pop_front());
            end
        end
    end

    initial begin
        reset        = 1'b0;
        hcount       = 10'd0;
        vcount       = 10'd0;
        da_in        = 1'b0;
        hs_in        = 1'b1;
        vs_in        = 1'b1;
        mem_gnt      = 1'b0;
        mem_data     = 32'h0;
        pend_valid   = 1'b0;
        pend_addr    = 32'h0;
        obs_req      = 1'b0;
        obs_addr     = 32'h0;
        bank_line    = '{-1, -1};
        exp_underrun = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] checking reset state");
        check_output("reset_mem_req", mem_req, 1'b0);
        check_output("reset_mem_addr", mem_addr, 32'h0);
        check_output("reset_rgb", rgb, 8'h00);
        check_output("reset_da_out", da_out, 1'b0);
        check_output("reset_hs_out", hs_out, 1'b1);
        check_output("reset_vs_out", vs_out, 1'b1);
        check_output("reset_underrun", underrun, 1'b0);

        $display("[TB] fetch of line 1 at vcount 3");
        run_line(3, 1'b1, -1, 40);

        $display("[TB] replay of line 1 on vcount 4..7");
        run_line(4, 1'b1, -1, 0);
        run_line(5, 1'b1, -1, 0);
        run_line(6, 1'b1, -1, 0);
        run_line(7, 1'b1, -1, 40);

        $display("[TB] vertical sync line");
        run_line(490, 1'b1, -1, 0);

        $display("[TB] end-of-frame fetch of line 0");
        run_line(524, 1'b1, -1, 40);
        run_line(0, 1'b1, -1, 0);

        $display("[TB] stalled fetch and underrun");
        run_line(3, 1'b0, -1, 159);
        run_line(4, 1'b1, -1, 0);
        run_line(7, 1'b1, -1, 40);

        $display("[TB] reset in the middle of a fetch");
        run_line(3, 1'b1, 661, 21);
        run_line(4, 1'b1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
